// File: rtl/regfile_mp.sv
// Multi-port register file with a hardwired zero register, two prioritised write
// lanes, optional write-to-read forwarding and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_addr
);

  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_reg  [DEPTH];
  logic [DATA_W-1:0] regs_next [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign regs_next[gi] = '0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_arch
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        logic hit0, hit1, mark_hit;
        assign hit0     = we0 && (waddr0 == IDX);
        assign hit1     = we1 && (waddr1 == IDX);
        assign mark_hit = mark_en && (mark_addr == IDX);
        assign regs_next[gi] = hit1 ? wdata1 : (hit0 ? wdata0 : regs_reg[gi]);
        // A newly issued producer outranks the one retiring in the same cycle.
        assign busy_next[gi] = mark_hit | (busy_reg[gi] & ~(hit0 | hit1));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= (i == ZERO_REG) ? '0 : DATA_W'(i);
      end
      busy_reg <= '0;
    end else begin
      regs_reg <= regs_next;
      busy_reg <= busy_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              fwd0, fwd1;
      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
      assign fwd1 = (BYPASS != 0) && we1 && (waddr1 == addr);
      assign fwd0 = (BYPASS != 0) && we0 && (waddr0 == addr);
      assign rd_data[gi*DATA_W +: DATA_W] =
        (addr == ZADDR) ? '0 : (fwd1 ? wdata1 : (fwd0 ? wdata0 : regs_reg[addr]));
      // A forwarded value is already available, so the reader need not stall.
      assign rd_busy[gi] = (addr != ZADDR) && busy_reg[addr] && !(fwd0 || fwd1);
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding and a non-forwarding instance share stimulus
// and are checked every cycle against an array model plus directed literal cases.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [9:0]   rd_addr = '0;
  logic         we0 = 1'b0, we1 = 1'b0, mark_en = 1'b0;
  logic [4:0]   waddr0 = '0, waddr1 = '0, mark_addr = '0;
  logic [63:0]  wdata0 = '0, wdata1 = '0;
  logic [127:0] rd_data_a, rd_data_b;
  logic [1:0]   rd_busy_a, rd_busy_b;

  int total = 0;
  int bad = 0;

  logic [63:0] m_mem [32];
  bit   [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .mark_en(mark_en), .mark_addr(mark_addr)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .mark_en(mark_en), .mark_addr(mark_addr)
  );

  // Architectural state: later assignments win, so lane 1 beats lane 0 and a mark beats a retire.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= (i == 31) ? 64'd0 : 64'(i);
      m_busy <= '0;
    end else begin
      if (we0 && waddr0 != 5'd31) begin m_mem[waddr0] <= wdata0; m_busy[waddr0] <= 1'b0; end
      if (we1 && waddr1 != 5'd31) begin m_mem[waddr1] <= wdata1; m_busy[waddr1] <= 1'b0; end
      if (mark_en && mark_addr != 5'd31) m_busy[mark_addr] <= 1'b1;
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 64'd0;
    if (byp && we1 && waddr1 == a) return wdata1;
    if (byp && we0 && waddr0 == a) return wdata0;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 1'b0;
    if (byp && ((we0 && waddr0 == a) || (we1 && waddr1 == a))) return 1'b0;
    return m_busy[a];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [4:0] a;
      a = rd_addr[k*5 +: 5];
      total += 4;
      if (rd_data_a[k*64 +: 64] !== exp_rd(a, 1'b1)) begin
        bad++;
        $display("FAIL model data byp=1 port%0d addr=%0d t=%0t: got %h want %h", k, a, $time, rd_data_a[k*64 +: 64], exp_rd(a, 1'b1));
      end
      if (rd_data_b[k*64 +: 64] !== exp_rd(a, 1'b0)) begin
        bad++;
        $display("FAIL model data byp=0 port%0d addr=%0d t=%0t: got %h want %h", k, a, $time, rd_data_b[k*64 +: 64], exp_rd(a, 1'b0));
      end
      if (rd_busy_a[k] !== exp_busy(a, 1'b1)) begin
        bad++;
        $display("FAIL model busy byp=1 port%0d addr=%0d t=%0t: got %b want %b", k, a, $time, rd_busy_a[k], exp_busy(a, 1'b1));
      end
      if (rd_busy_b[k] !== exp_busy(a, 1'b0)) begin
        bad++;
        $display("FAIL model busy byp=0 port%0d addr=%0d t=%0t: got %b want %b", k, a, $time, rd_busy_b[k], exp_busy(a, 1'b0));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; mark_en = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    rd_addr = {5'd31, 5'd5};
    #2;
    chk("reset rd0 addr5", rd_data_a[63:0], 64'd5);
    chk("reset rd1 addr31", rd_data_a[127:64], 64'd0);
    chk("reset busy", 64'(rd_busy_a), 64'd0);
    #9 rst_n = 1'b1;

    // Single write, forwarded vs stored
    step(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 64'hDEAD; rd_addr = {5'd31, 5'd3};
    #1;
    chk("wr3 byp same cycle", rd_data_a[63:0], 64'hDEAD);
    chk("wr3 nobyp same cycle", rd_data_b[63:0], 64'd3);
    step(); idle(); #1;
    chk("wr3 byp after edge", rd_data_a[63:0], 64'hDEAD);
    chk("wr3 nobyp after edge", rd_data_b[63:0], 64'hDEAD);

    // Dual-lane collision, then zero-register write
    step(); we0 = 1'b1; waddr0 = 5'd7; wdata0 = 64'h11; we1 = 1'b1; waddr1 = 5'd7; wdata1 = 64'h22;
    rd_addr = {5'd31, 5'd7};
    #1 chk("collide7 bypass", rd_data_a[63:0], 64'h22);
    step(); idle(); #1;
    chk("collide7 stored", rd_data_b[63:0], 64'h22);
    step(); we0 = 1'b1; waddr0 = 5'd31; wdata0 = 64'hFF;
    #1 chk("xzr write same cycle", rd_data_a[127:64], 64'd0);
    step(); idle(); #1;
    chk("xzr after edge", rd_data_b[127:64], 64'd0);

    // Mark then retire on lane 1
    step(); mark_en = 1'b1; mark_addr = 5'd9; rd_addr = {5'd31, 5'd9};
    #1 chk("mark9 same cycle busy", 64'(rd_busy_a[0]), 64'd0);
    step(); idle(); #1;
    chk("mark9 next busy", 64'(rd_busy_a[0]), 64'd1);
    step(); we1 = 1'b1; waddr1 = 5'd9; wdata1 = 64'h55;
    #1;
    chk("wr9 byp busy", 64'(rd_busy_a[0]), 64'd0);
    chk("wr9 byp data", rd_data_a[63:0], 64'h55);
    chk("wr9 nobyp busy", 64'(rd_busy_b[0]), 64'd1);
    step(); idle(); #1;
    chk("wr9 busy cleared", 64'(rd_busy_b[0]), 64'd0);

    // Mark and write same register in one cycle
    step(); mark_en = 1'b1; mark_addr = 5'd12; we0 = 1'b1; waddr0 = 5'd12; wdata0 = 64'hABC;
    rd_addr = {5'd31, 5'd12};
    step(); idle(); #1;
    chk("mark+wr12 busy", 64'(rd_busy_b[0]), 64'd1);
    chk("mark+wr12 data", rd_data_b[63:0], 64'hABC);

    // Asynchronous reset between edges
    step(); we0 = 1'b1; waddr0 = 5'd4; wdata0 = 64'h77; rd_addr = {5'd31, 5'd4};
    step(); idle(); mark_en = 1'b1; mark_addr = 5'd4;
    step(); idle(); #1;
    chk("r4 before reset data", rd_data_b[63:0], 64'h77);
    chk("r4 before reset busy", 64'(rd_busy_b[0]), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("r4 async reset data", rd_data_b[63:0], 64'd4);
    chk("r4 async reset busy", 64'(rd_busy_b[0]), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Random traffic concentrated on a few registers plus XZR
    for (int n = 0; n < 2000; n++) begin
      step();
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      mark_en = 1'($urandom_range(0, 1));
      waddr0 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      waddr1 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      mark_addr = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      wdata0 = {$urandom, $urandom};
      wdata1 = {$urandom, $urandom};
      rd_addr[4:0] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      rd_addr[9:5] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    step(); idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, clocked successor of the LEGv8 datapath register file.
- Provides NUM_RD read ports, two write ports with defined priority, and a hardwired zero register (XZR).
- Optional write-to-read bypass, plus a per-register busy scoreboard for the pipelined core's hazard unit.
- Sits between decode (reads, busy marking) and writeback (two retire lanes).

Parameters:
- DATA_W, 64, register width in bits
- DEPTH, 32, number of architectural registers (power of two)
- ADDR_W, 5, log2(DEPTH)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 31, index hardwired to zero (XZR)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  scoreboard busy flag for each read address
- we0  in  1  write enable, lane 0
- waddr0  in  ADDR_W  write address, lane 0
- wdata0  in  DATA_W  write data, lane 0
- we1  in  1  write enable, lane 1 (higher priority)
- waddr1  in  ADDR_W  write address, lane 1
- wdata1  in  DATA_W  write data, lane 1
- mark_en  in  1  set busy bit for mark_addr (producer issued)
- mark_addr  in  ADDR_W  register to mark busy

Behaviour:
- Reset: while rst_n=0, asynchronously:
  - reg[i] = i (zero-extended) for i != ZERO_REG; reg[ZERO_REG] = 0
  - all busy bits cleared
  - rd_data and rd_busy follow the combinational rules below from this reset state.
- Writes: at each rising clk edge, reg[waddrN] <= wdataN when weN=1.
  - Both lanes to the same address: lane 1 wins; lane 0 is dropped.
  - Different addresses: both commit.
  - Writes to ZERO_REG are discarded.
- Reads (0-cycle latency, combinational), per port k:
  - addr == ZERO_REG -> 0, regardless of writes or BYPASS.
  - Else if BYPASS=1 and we1 && waddr1 == addr -> wdata1.
  - Else if BYPASS=1 and we0 && waddr0 == addr -> wdata0.
  - Else -> reg[addr].
  - BYPASS=0: stored value only; the new value is visible the cycle after the write.
- Scoreboard, per register, at the clock edge:
  - A write on either lane clears busy[waddr].
  - mark_en sets busy[mark_addr].
  - Mark and write to the same address in one cycle: mark wins, busy=1. A new producer supersedes the retiring one.
  - busy[ZERO_REG] stays 0; marks to it are ignored.
- rd_busy[k]:
  - busy[rd_addr[k]], forced to 0 when rd_addr[k] is being written this cycle and BYPASS=1 (value is forwarded).
  - Always 0 for ZERO_REG.
  - Reflects stored busy only; a same-cycle mark_en does not assert it until the next cycle.
- Reset mid-operation:
  - Pending writes and marks in that cycle are lost.
  - Contents return to reset values immediately, without waiting for a clock edge.
- No X propagation: all unused or invalid conditions resolve to defined values. Addresses are always in range because DEPTH = 2^ADDR_W.

Test Plan:
- Reset release, read ports at addr 5 and 31 -> rd_data = 5 and 0; rd_busy = 0,0.
- we0=1, waddr0=3, wdata0=0xDEAD, rd_addr port0=3, BYPASS=1 -> rd_data=0xDEAD in the same cycle and stored after the edge. With BYPASS=0 -> 3 in that cycle, 0xDEAD in the next.
- Both lanes to addr 7 (wdata0=0x11, wdata1=0x22) -> bypass value 0x22; reg[7]=0x22 after the edge. Write 0xFF to addr 31 -> read still 0.
- mark_en with addr 9 -> rd_busy for addr 9 = 1 the next cycle. we1 to 9 with 0x55 -> rd_busy=0 and rd_data=0x55 in the write cycle; busy cleared after the edge.
- mark_en and we0 both on addr 12 in one cycle -> busy[12]=1 afterwards; reg[12] holds the written value.
- Write 0x77 to addr 4, then mark addr 4, then pull rst_n low between edges -> reg[4]=4 and busy[4]=0 immediately, with no clock edge.
